serial_loader: RTL
==================

# serial_loader

Byte-serial loader that sits directly upstream of the 8-bit `register` stage and drives its `data_i`/`load_i` pair. It receives an SPI-style frame (mode 0, MSB first) from an external host through an asynchronous serial clock, and synchronises all inputs into `clk_i`. It then emits one single-cycle load strobe per received data byte, together with a target address that auto-increments. It lets a host preload register contents without parallel pins.

## Interface
- `DATA_W`, default 8: width of `data_o` and of each serial byte.
- `ADDR_W`, default 4: width of `addr_o`; selects one of 2^ADDR_W target registers.
- `SYNC_STAGES`, default 2: flip-flop stages in each input synchroniser; legal values are 2 or 3.
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `sclk_i`  in  1  host serial clock, asynchronous to `clk_i`.
- `cs_ni`  in  1  host chip select, active-low; frames a transfer.
- `mosi_i`  in  1  host serial data, sampled on rising `sclk_i`.
- `data_o`  out  DATA_W  last completed data byte; feeds the register's `data_i`.
- `addr_o`  out  ADDR_W  target register index for the current byte.
- `load_o`  out  1  one-cycle write strobe; feeds the register's `load_i` (qualified by decode of `addr_o`).
- `busy_o`  out  1  high while a frame is active.
- `frame_err_o`  out  1  sticky flag: the last frame ended mid-byte.

## Operation
- **Input synchronisation:** `sclk_i`, `cs_ni` and `mosi_i` each pass through SYNC_STAGES flops. Reset levels of these flops are 0, 1 and 0 respectively.
- **Edge detection:** one extra flop on synced sclk. A rising edge is synced sclk = 1 while the previous value = 0.
- **Frame start:** a synced `cs_ni` 1→0 transition moves the FSM from IDLE to ADDR. It also clears the bit counter, the shift register and `frame_err_o`.
- **Bit capture:** on each sclk rising edge with synced cs low, do `shift <= {shift[DATA_W-2:0], mosi_sync}` and increment the 3-bit (log2 DATA_W) bit counter. When the counter wraps from DATA_W-1 to 0, the byte is complete.
- **FSM states:** IDLE, ADDR, DATA.
  - IDLE→ADDR on cs assert.
  - ADDR, byte complete: `addr_o <= byte[ADDR_W-1:0]` (upper bits ignored); go to DATA; no load.
  - DATA, byte complete: `data_o <= byte` and `load_o <= 1` for exactly one cycle. On the cycle after the strobe, `addr_o` increments modulo 2^ADDR_W (15→0 at ADDR_W=4). Stay in DATA.
  - Any state, synced cs deassert (0→1): go to IDLE. If the bit counter ≠ 0, discard the partial byte and set `frame_err_o`.
- **Simultaneous events:** cs deassert and an sclk edge detected in the same cycle means the cs deassert wins and the edge is ignored.
- **Persistence:** `data_o` and `addr_o` hold their values between frames. They change only as described above.
- `busy_o` = (state ≠ IDLE).
- An address-only frame (cs released right after the address byte) produces no load and no error.

## Timing
- **Reset values:** `data_o`=0, `addr_o`=0, `load_o`=0, `busy_o`=0, `frame_err_o`=0, state IDLE.
- **Asynchronous reset:** assertion mid-frame clears everything immediately. The next frame only starts after a fresh synced cs falling edge.
- **Latency:** the edge-detect flop sees the rising `sclk_i` of the last bit after SYNC_STAGES+1 clocks. `data_o` updates and `load_o` rises on the next clock edge. Total: SYNC_STAGES+2 `clk_i` cycles from the pin edge to `load_o`.
- **Output stability:** `data_o` and `addr_o` are stable for the whole cycle in which `load_o`=1. `addr_o` changes only on the cycle after that.
- **Host constraints:**
  - Each `sclk_i` high and low phase must be ≥ SYNC_STAGES `clk_i` periods, so sclk ≤ clk/(2·SYNC_STAGES).
  - `mosi_i` must be stable ≥ 1 `clk_i` period around the rising `sclk_i`.
  - `cs_ni` must fall ≥ SYNC_STAGES+1 clocks before the first sclk edge and rise ≥ SYNC_STAGES+1 clocks after the last.
- **Load spacing:** `load_o` pulses are at least 2·DATA_W·SYNC_STAGES cycles apart, so the downstream register needs no backpressure.

## Test plan
- **Reset:** hold `rst_ni`=0 for 3 cycles while toggling the serial pins → all outputs 0 and `busy_o`=0 throughout; release → outputs unchanged.
- **Single byte:** frame with address 0x03, data 0xA5, sclk = clk/8 → exactly one `load_o` pulse, with `data_o`=0xA5 and `addr_o`=3 in that cycle; `addr_o`=4 afterwards; the register's `out_o` reads 0xA5; `busy_o` falls SYNC_STAGES+1 cycles after `cs_ni` rises.
- **Burst with wrap:** address 0x0E, data 0x11, 0x22, 0x33 → three pulses at `addr_o` = 14, 15, 0 with matching data; `frame_err_o`=0.
- **Aborted byte:** address 0x02, then 5 data bits, then cs released → no `load_o`; `frame_err_o`=1 and `data_o` unchanged. The next valid frame clears `frame_err_o` at cs assert.
- **Address only:** frame 0xF7 only → no load, `addr_o`=7, `frame_err_o`=0.
- **Reset mid-frame:** reset pulse after 4 data bits → outputs return to 0 at once; a following full frame (address 0x01, data 0x5A) loads normally.

Source files
------------

// File: rtl/serial_loader.sv
// serial_loader: SPI mode-0 (MSB first) byte receiver that turns an address
// byte followed by data bytes into single-cycle load strobes with an
// auto-incrementing target address, all in the clk_i domain.
module serial_loader #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sclk_i,
  input  logic              cs_ni,
  input  logic              mosi_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              load_o,
  output logic              busy_o,
  output logic              frame_err_o
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Synchroniser chains; sample enters at bit 0, synced value leaves the top.
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  logic                   w_sclk_s;
  logic                   w_cs_s;
  logic                   w_mosi_s;
  logic                   w_sclk_rise;
  logic                   w_cs_fall;
  logic                   w_cs_rise;

  // Bit capture datapath.
  logic [DATA_W-1:0]      r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_byte_done;

  // FSM state and registered outputs.
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DATA_W-1:0]      r_data;
  logic [DATA_W-1:0]      w_data_nxt;
  logic [ADDR_W-1:0]      r_addr;
  logic [ADDR_W-1:0]      w_addr_nxt;
  logic                   r_load;
  logic                   w_load_nxt;
  logic                   r_busy;
  logic                   r_err;
  logic                   w_err_nxt;

  // Input synchronisers; reset levels match an idle bus (sclk low, cs high).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_ni};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  // Edge detection on the synchronised pins.
  always_comb begin
    w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    w_cs_fall   = r_cs_prev & ~w_cs_s;
    w_cs_rise   = ~r_cs_prev & w_cs_s;
  end

  // Shift in one bit per sclk rising edge while a frame is active; flag a
  // completed byte for one cycle so the FSM acts on the full shift value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_byte_done <= 1'b0;
    end else begin
      r_byte_done <= 1'b0;
      if (w_cs_fall) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_sclk_rise && !w_cs_s && (r_state != ST_IDLE)) begin
        r_shift <= {r_shift[DATA_W-2:0], w_mosi_s};
        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
          r_bit_cnt   <= '0;
          r_byte_done <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  // FSM state and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_addr  <= '0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_addr  <= w_addr_nxt;
      r_load  <= w_load_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and output decode; cs deassert takes priority over a byte.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_addr_nxt  = r_addr;
    w_load_nxt  = 1'b0;
    w_err_nxt   = r_err;

    // Address advances on the cycle after each strobe.
    if (r_load) begin
      w_addr_nxt = r_addr + ADDR_W'(1);
    end

    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_ADDR;
          w_err_nxt   = 1'b0;
        end
      end
      ST_ADDR: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          if (r_bit_cnt != '0) begin
            w_err_nxt = 1'b1;
          end
        end else if (r_byte_done) begin
          w_addr_nxt  = r_shift[ADDR_W-1:0];
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          if (r_bit_cnt != '0) begin
            w_err_nxt = 1'b1;
          end
        end else if (r_byte_done) begin
          w_data_nxt = r_shift;
          w_load_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign data_o      = r_data;
  assign addr_o      = r_addr;
  assign load_o      = r_load;
  assign busy_o      = r_busy;
  assign frame_err_o = r_err;

endmodule
